// File: rtl/dma_pkg.sv
// dma_pkg: shared definitions for the DMA status generator.
//   - dma_state_e  : FSM state encoding
//   - dma_desc_t   : latched descriptor fields from the fetch stage
//   - status word geometry {last, index[7:0], bytes[15:0]}
//   - popcount4    : number of enabled bytes in a 32-bit beat
package dma_pkg;

    localparam int unsigned LEN_W     = 16;
    localparam int unsigned IDX_W     = 8;
    localparam int unsigned BE_W      = 4;
    localparam int unsigned CNT_W     = LEN_W + 1;
    localparam int unsigned POP_W     = 3;
    localparam int unsigned STATUS_W  = 25;
    localparam int unsigned LAST_BIT  = 24;
    localparam int unsigned IDX_MSB   = 23;
    localparam int unsigned IDX_LSB   = 16;
    localparam int unsigned BYTES_MSB = 15;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        PUSH   = 2'd2,
        DONE   = 2'd3
    } dma_state_e;

    typedef struct packed {
        logic             last;
        logic [IDX_W-1:0] index;
        logic [LEN_W-1:0] length;
    } dma_desc_t;

    // Count of set byte enables (0..4)
    function automatic logic [POP_W-1:0] popcount4(input logic [BE_W-1:0] be);
        return POP_W'(be[0]) + POP_W'(be[1]) + POP_W'(be[2]) + POP_W'(be[3]);
    endfunction

endpackage

// File: rtl/dma_byte_counter.sv
// dma_byte_counter: per-descriptor byte accumulator.
// Ports:
//   clk, reset_n  - clock, async active-low reset
//   clear         - restart the count at 0 (descriptor accepted)
//   beat_en       - accepted write beat while the transfer is active
//   be            - byte enables of that beat
//   length        - latched programmed length
//   done_c        - post-add count >= length (combinational)
//   bytes_c       - count saturated to 16 bits (combinational from register)
//   overrun       - sticky, count has exceeded length since reset
module dma_byte_counter
    import dma_pkg::*;
(
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clear,
    input  logic             beat_en,
    input  logic [BE_W-1:0]  be,
    input  logic [LEN_W-1:0] length,
    output logic             done_c,
    output logic [LEN_W-1:0] bytes_c,
    output logic             overrun
);

    localparam int unsigned SUM_W = CNT_W + 1;

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_nxt_c;
    logic [SUM_W-1:0] sum_c;

    // Post-add count; the 17-bit accumulator sticks at all-ones instead of wrapping
    always_comb begin
        sum_c       = {1'b0, count_q} + SUM_W'(popcount4(be));
        count_nxt_c = count_q;
        if (beat_en) begin
            count_nxt_c = sum_c[SUM_W-1] ? '1 : sum_c[CNT_W-1:0];
        end
    end

    assign done_c  = count_nxt_c >= CNT_W'(length);
    assign bytes_c = (|count_q[CNT_W-1:LEN_W]) ? '1 : count_q[LEN_W-1:0];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
            overrun <= 1'b0;
        end else begin
            count_q <= clear ? '0 : count_nxt_c;
            if (beat_en && (count_nxt_c > CNT_W'(length))) begin
                overrun <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/dma_status_gen.sv
// dma_status_gen: tracks one descriptor's write beats and pushes a status word.
// Ports:
//   clk, reset_n                  - clock, async active-low reset
//   desc_valid_i/desc_ready_o     - descriptor handshake with the fetch stage
//   desc_index_i/length_i/last_i  - descriptor fields
//   wr_enable_o                   - write master may issue beats (ACTIVE only)
//   wr_beat_i/wr_be_i/wr_eop_i    - accepted beat, its byte enables, early end
//   dma_status_fifo_almost_full_i - status stage back-pressure
//   dma_status_fifo_wr_req_o      - one-cycle status push
//   dma_status_fifo_data_o        - {last, index, bytes}, valid with wr_req
//   overrun_o                     - sticky length overrun
//   chain_done_o                  - pulse after the last descriptor's status push
module dma_status_gen
    import dma_pkg::*;
(
    input  logic                clk,
    input  logic                reset_n,
    input  logic                desc_valid_i,
    output logic                desc_ready_o,
    input  logic [IDX_W-1:0]    desc_index_i,
    input  logic [LEN_W-1:0]    desc_length_i,
    input  logic                desc_last_i,
    output logic                wr_enable_o,
    input  logic                wr_beat_i,
    input  logic [BE_W-1:0]     wr_be_i,
    input  logic                wr_eop_i,
    input  logic                dma_status_fifo_almost_full_i,
    output logic                dma_status_fifo_wr_req_o,
    output logic [STATUS_W-1:0] dma_status_fifo_data_o,
    output logic                overrun_o,
    output logic                chain_done_o
);

    dma_state_e        state_q, state_d;
    dma_desc_t         desc_q;
    logic              accept_c;
    logic              beat_en_c;
    logic              done_c;
    logic [LEN_W-1:0]  bytes_c;
    logic              push_d;
    logic              ready_d;
    logic              wr_en_d;
    logic              chain_done_d;
    logic [STATUS_W-1:0] data_d;

    assign accept_c  = (state_q == IDLE) && desc_ready_o && desc_valid_i;
    assign beat_en_c = wr_beat_i && (state_q == ACTIVE);

    dma_byte_counter u_byte_counter (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (accept_c),
        .beat_en (beat_en_c),
        .be      (wr_be_i),
        .length  (desc_q.length),
        .done_c  (done_c),
        .bytes_c (bytes_c),
        .overrun (overrun_o)
    );

    // Next state and next values of the registered outputs
    always_comb begin
        state_d      = state_q;
        push_d       = 1'b0;
        data_d       = dma_status_fifo_data_o;
        case (state_q)
            IDLE:   if (accept_c) state_d = ACTIVE;
            ACTIVE: if (done_c || (beat_en_c && wr_eop_i)) state_d = PUSH;
            PUSH: begin
                if (!dma_status_fifo_almost_full_i) begin
                    push_d  = 1'b1;
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (push_d) begin
            data_d[LAST_BIT]        = desc_q.last;
            data_d[IDX_MSB:IDX_LSB] = desc_q.index;
            data_d[BYTES_MSB:0]     = bytes_c;
        end
        ready_d      = (state_d == IDLE);
        wr_en_d      = (state_d == ACTIVE);
        chain_done_d = (state_q == DONE) && desc_q.last;
    end

    // State, latched descriptor and registered outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q                  <= IDLE;
            desc_q                   <= '0;
            desc_ready_o             <= 1'b0;
            wr_enable_o              <= 1'b0;
            dma_status_fifo_wr_req_o <= 1'b0;
            dma_status_fifo_data_o   <= '0;
            chain_done_o             <= 1'b0;
        end else begin
            state_q                  <= state_d;
            if (accept_c) begin
                desc_q <= '{last: desc_last_i, index: desc_index_i, length: desc_length_i};
            end
            desc_ready_o             <= ready_d;
            wr_enable_o              <= wr_en_d;
            dma_status_fifo_wr_req_o <= push_d;
            dma_status_fifo_data_o   <= data_d;
            chain_done_o             <= chain_done_d;
        end
    end

endmodule
